// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv3d window scheduler.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Valid output extent along one axis for stride 1, no padding.
    function automatic int out_dim(input int fm, input int kern);
        return fm - kern + 1;
    endfunction

endpackage

// File: rtl/conv3d_sched_if.sv
// Window request channel: win_vld/win_rdy handshake carrying output-position coordinates.
// A request transfers on a cycle with win_vld & win_rdy; coordinates stay stable while win_vld waits on win_rdy.
interface conv3d_sched_if #(
    parameter int ZW = 3,
    parameter int YW = 3,
    parameter int XW = 3
);
    logic          win_vld;
    logic          win_rdy;
    logic [ZW-1:0] win_z;
    logic [YW-1:0] win_y;
    logic [XW-1:0] win_x;

    modport master (
        output win_vld,
        output win_z,
        output win_y,
        output win_x,
        input  win_rdy
    );

    modport slave (
        input  win_vld,
        input  win_z,
        input  win_y,
        input  win_x,
        output win_rdy
    );
endinterface

// File: rtl/conv3d_coord_gen.sv
// Raster-order (x fastest, then y, then z) output-position counter for the window scheduler.
module conv3d_coord_gen #(
    parameter int OL = 6,
    parameter int OH = 6,
    parameter int OW = 6,
    parameter int ZW = 3,
    parameter int YW = 3,
    parameter int XW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    output logic [ZW-1:0] z,
    output logic [YW-1:0] y,
    output logic [XW-1:0] x,
    output logic          last
);

    logic [ZW-1:0] z_q, z_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x_q, x_d;
    logic          x_end, y_end, z_end;

    assign x_end = (x_q == XW'(OW - 1));
    assign y_end = (y_q == YW'(OH - 1));
    assign z_end = (z_q == ZW'(OL - 1));
    assign last  = x_end & y_end & z_end;

    always_comb begin
        z_d = z_q;
        y_d = y_q;
        x_d = x_q;
        if (clear) begin
            z_d = '0;
            y_d = '0;
            x_d = '0;
        end else if (step) begin
            if (x_end) begin
                x_d = '0;
                if (y_end) begin
                    y_d = '0;
                    z_d = z_end ? '0 : z_q + ZW'(1);
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= '0;
            y_q <= '0;
            x_q <= '0;
        end else begin
            z_q <= z_d;
            y_q <= y_d;
            x_q <= x_d;
        end
    end

    assign z = z_q;
    assign y = y_q;
    assign x = x_q;

endmodule

// File: rtl/conv3d_sched.sv
// Conv3d window scheduler: sweeps every output position of a volume, throttled by downstream
// FIFO credits, and tracks in-flight kernel results so the sweep ends only once all are back.
module conv3d_sched
    import conv_pkg::*;
#(
    parameter int FM_L      = 8,
    parameter int FM_H      = 8,
    parameter int FM_W      = 8,
    parameter int KERN_L    = 3,
    parameter int KERN_H    = 3,
    parameter int KERN_W    = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    conv3d_sched_if.master        win,
    input  logic                  k_dout_vld,
    input  logic                  res_pop,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  err,
    output sched_state_t          dbg_state
);

    localparam int OL = out_dim(FM_L, KERN_L);
    localparam int OH = out_dim(FM_H, KERN_H);
    localparam int OW = out_dim(FM_W, KERN_W);
    localparam int ZW = clog2_min1(OL);
    localparam int YW = clog2_min1(OH);
    localparam int XW = clog2_min1(OW);
    localparam int CW = clog2_min1(OUT_DEPTH + 1);
    // Outstanding is sized past the worst legal value so a misbehaving kernel saturates it.
    localparam int NW = clog2_min1(OL * OH * OW + OUT_DEPTH + 1);

    sched_state_t  state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [NW-1:0] outst_q, outst_d;
    logic          aborted_q, aborted_d;
    logic          err_q, err_d;

    logic          win_vld;
    logic          fire;
    logic          coord_clear;
    logic          coord_last;
    logic [ZW-1:0] coord_z;
    logic [YW-1:0] coord_y;
    logic [XW-1:0] coord_x;

    assign win_vld = (state_q == RUN) && (credit_q != '0);
    assign fire    = win_vld && win.win_rdy;

    conv3d_coord_gen #(
        .OL (OL),
        .OH (OH),
        .OW (OW),
        .ZW (ZW),
        .YW (YW),
        .XW (XW)
    ) u_coord (
        .clk   (clk),
        .rst_n (reset_n),
        .clear (coord_clear),
        .step  (fire),
        .z     (coord_z),
        .y     (coord_y),
        .x     (coord_x),
        .last  (coord_last)
    );

    always_comb begin
        state_d     = state_q;
        aborted_d   = aborted_q;
        coord_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    aborted_d   = 1'b0;
                    coord_clear = 1'b1;
                end
            end
            RUN: begin
                // Abort wins over a coincident final fire; the fire is still accounted below.
                if (abort) begin
                    state_d   = DRAIN;
                    aborted_d = 1'b1;
                end else if (fire && coord_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((outst_q == '0) && !fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        if (fire && !res_pop) begin
            credit_d = credit_q - CW'(1);
        end else if (res_pop && !fire && (credit_q != CW'(OUT_DEPTH))) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (fire && !k_dout_vld) begin
            if (outst_q != '1) begin
                outst_d = outst_q + NW'(1);
            end
        end else if (k_dout_vld && !fire && (outst_q != '0)) begin
            outst_d = outst_q - NW'(1);
        end
    end

    always_comb begin
        err_d = err_q;
        if (k_dout_vld && (outst_q == '0)) begin
            err_d = 1'b1;
        end
        if (res_pop && (credit_q == CW'(OUT_DEPTH))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            credit_q  <= CW'(OUT_DEPTH);
            outst_q   <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            outst_q   <= outst_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    assign win.win_vld = win_vld;
    assign win.win_z   = coord_z;
    assign win.win_y   = coord_y;
    assign win.win_x   = coord_x;

    assign res_last  = k_dout_vld && (state_q == DRAIN) && (outst_q == NW'(1)) && !aborted_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign aborted   = aborted_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
